// File: rtl/buf_fifo.sv
`default_nettype none
// ============================================================================
// buf_fifo : WIDTH x DEPTH first-word fall-through elastic buffer with
//            valid/ready handshakes. Optional LEVEL port via BUF_FIFO_LEVEL_EN.
// Revision : 1.0
// ============================================================================
module buf_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       C,
  input  logic                       R,
  input  logic [WIDTH-1:0]           I,
  input  logic                       I_VLD,
  output logic                       I_RDY,
  output logic [WIDTH-1:0]           O,
  output logic                       O_VLD,
  input  logic                       O_RDY
`ifdef BUF_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] LEVEL
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [CW-1:0]    cnt;
  logic             push;
  logic             pop;

  // Ready depends only on registered occupancy and reset, never on I_VLD/O_RDY.
  assign I_RDY = (cnt != FULL_CNT) & ~R;
  assign O_VLD = (cnt != '0);
  assign O     = O_VLD ? mem[rp] : '0;
  assign push  = I_VLD & I_RDY;
  assign pop   = O_VLD & O_RDY;

`ifdef BUF_FIFO_LEVEL_EN
  assign LEVEL = cnt;
`endif

  always_ff @(posedge C) begin
    if (push) begin
      mem[wp] <= I;
    end
  end

  always_ff @(posedge C) begin
    if (R) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        wp <= wp + 1'b1;
      end
      if (pop) begin
        rp <= rp + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_buf_fifo.sv
`default_nettype none
// Directed self-checking bench for buf_fifo (WIDTH=8, DEPTH=4).
module tb_buf_fifo;

  logic       C = 1'b0;
  logic       R;
  logic [7:0] I;
  logic       I_VLD;
  logic       I_RDY;
  logic [7:0] O;
  logic       O_VLD;
  logic       O_RDY;
`ifdef BUF_FIFO_LEVEL_EN
  logic [2:0] LEVEL;
`endif

  int checks = 0;
  int errors = 0;

  buf_fifo #(.WIDTH(8), .DEPTH(4)) dut (
    .C     (C),
    .R     (R),
    .I     (I),
    .I_VLD (I_VLD),
    .I_RDY (I_RDY),
    .O     (O),
    .O_VLD (O_VLD),
    .O_RDY (O_RDY)
`ifdef BUF_FIFO_LEVEL_EN
    ,
    .LEVEL (LEVEL)
`endif
  );

  always #5 C = ~C;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_lvl(input string tag, input int exp);
`ifdef BUF_FIFO_LEVEL_EN
    chk(tag, 32'(LEVEL), 32'(exp));
`endif
  endtask

  task automatic step();
    @(posedge C);
    #1;
  endtask

  task automatic push_one(input logic [7:0] v);
    I = v;
    I_VLD = 1'b1;
    step();
    I_VLD = 1'b0;
  endtask

  initial begin
    logic [7:0] fill_q [4];
    logic [7:0] tail_q [4];
    fill_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    tail_q = '{8'hA2, 8'hA3, 8'hA4, 8'h66};

    // Reset then idle
    R = 1'b1; I = '0; I_VLD = 1'b0; O_RDY = 1'b0;
    step();
    chk("rst_irdy0", 32'(I_RDY), 0);
    step();
    chk("rst_irdy1", 32'(I_RDY), 0);
    chk("rst_ovld", 32'(O_VLD), 0);
    R = 1'b0;
    #1;
    chk("idle_irdy", 32'(I_RDY), 1);
    chk("idle_ovld", 32'(O_VLD), 0);
    chk("idle_o", 32'(O), 0);
    chk_lvl("idle_lvl", 0);

    // Fill with consumer stalled
    for (int k = 0; k < 4; k++) begin
      I = fill_q[k];
      I_VLD = 1'b1;
      step();
    end
    I = 8'h55;
    chk("full_irdy", 32'(I_RDY), 0);
    chk("full_o", 32'(O), 32'h11);
    chk("full_ovld", 32'(O_VLD), 1);
    chk_lvl("full_lvl", 4);
    step();
    chk("hold_o", 32'(O), 32'h11);
    chk("hold_irdy", 32'(I_RDY), 0);
    chk_lvl("hold_lvl", 4);
    I_VLD = 1'b0;

    // Drain
    O_RDY = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain_o%0d", k), 32'(O), 32'(fill_q[k]));
      step();
      if (k == 0) chk("drain_irdy", 32'(I_RDY), 1);
    end
    chk("drain_ovld", 32'(O_VLD), 0);
    chk("drain_o", 32'(O), 0);
    O_RDY = 1'b0;

    // Streaming with wrap after one-word prefill
    push_one(8'h01);
    O_RDY = 1'b1;
    I_VLD = 1'b1;
    for (int v = 2; v <= 10; v++) begin
      I = 8'(v);
      chk($sformatf("strm_o%0d", v - 1), 32'(O), 32'(v - 1));
      chk_lvl($sformatf("strm_lvl%0d", v), 1);
      step();
    end
    I_VLD = 1'b0;
    chk("strm_o10", 32'(O), 32'h0A);
    step();
    chk("strm_empty", 32'(O_VLD), 0);
    O_RDY = 1'b0;

    // Full plus simultaneous pop
    for (int k = 0; k < 4; k++) push_one(8'hA1 + 8'(k));
    I = 8'h66; I_VLD = 1'b1; O_RDY = 1'b1;
    chk("fp_irdy", 32'(I_RDY), 0);
    chk("fp_o", 32'(O), 32'hA1);
    step();
    chk("fp_irdy_after", 32'(I_RDY), 1);
    chk_lvl("fp_lvl3", 3);
    O_RDY = 1'b0;
    step();
    I_VLD = 1'b0;
    chk_lvl("fp_lvl4", 4);
    chk("fp_full_again", 32'(I_RDY), 0);
    O_RDY = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("fp_o%0d", k), 32'(O), 32'(tail_q[k]));
      step();
    end
    chk("fp_empty", 32'(O_VLD), 0);
    O_RDY = 1'b0;

    // Reset mid-operation
    for (int k = 0; k < 3; k++) push_one(8'hB1 + 8'(k));
    chk("mid_ovld", 32'(O_VLD), 1);
    R = 1'b1;
    step();
    R = 1'b0;
    #1;
    chk("mr_ovld", 32'(O_VLD), 0);
    chk("mr_o", 32'(O), 0);
    chk("mr_irdy", 32'(I_RDY), 1);
    chk_lvl("mr_lvl", 0);
    push_one(8'h77);
    chk("mr_first_o", 32'(O), 32'h77);
    chk("mr_first_v", 32'(O_VLD), 1);
    O_RDY = 1'b1;
    step();
    chk("mr_final_empty", 32'(O_VLD), 0);
    O_RDY = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
